// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a sync_fifo (1-cycle read latency) into a valid/ready stream via a 2-entry skid buffer
module fifo_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  input  logic                 fifo_empty,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  input  logic                 flush,
  output logic [1:0]           buf_count,
  output logic [CNT_WIDTH-1:0] words_out
);
  logic [WIDTH-1:0]     buf0_q, buf0_d, buf1_q, buf1_d, s0, s1;
  logic [1:0]           cnt_q, cnt_d, c1;
  logic                 inflight_q, inflight_d, pop;
  logic [2:0]           occ;
  logic [CNT_WIDTH-1:0] words_q, words_d;
  always_comb begin
    pop        = (cnt_q != 2'd0) & m_ready;
    occ        = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    fifo_rd_en = !rst & !flush & !fifo_empty & (occ < 3'd2);
    c1         = cnt_q - {1'b0, pop};
    s0         = pop ? buf1_q : buf0_q;
    s1         = pop ? '0 : buf1_q;
    cnt_d      = flush ? 2'd0 : c1 + {1'b0, inflight_q};
    // head is forced to zero whenever the buffer ends up empty so m_data reads 0
    buf0_d     = (cnt_d == 2'd0) ? '0 : (inflight_q && c1 == 2'd0) ? fifo_rd_data : s0;
    buf1_d     = flush ? '0 : (inflight_q && c1 == 2'd1) ? fifo_rd_data : s1;
    inflight_d = fifo_rd_en;
    words_d    = words_q + CNT_WIDTH'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      words_q    <= '0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      words_q    <= words_d;
    end
  end
  assign m_valid   = cnt_q != 2'd0;
  assign m_data    = buf0_q;
  assign buf_count = cnt_q;
  assign words_out = words_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: queue-based FIFO + stream reference model, table vectors, directed corners, random run
module tb_fifo_stream_reader;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, m_ready = 1'b0, fifo_empty = 1'b1;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_en, m_valid;
  logic [31:0] m_data;
  logic [1:0]  buf_count;
  logic [3:0]  words_out;

  fifo_stream_reader #(.WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .flush(flush), .buf_count(buf_count), .words_out(words_out)
  );

  always #5 clk = ~clk;

  int unsigned fifo_q[$];
  int unsigned pending[$];
  bit          prev_rd, started;
  int          exp_words, n_cmp, n_bad;
  logic        s_rd, s_valid, s_pop, s_rst, s_flush;
  logic [31:0] s_data;
  logic [1:0]  s_buf;
  logic [3:0]  s_words;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(int unsigned w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // pending = words taken from the FIFO and not yet delivered; its head is the stream word
  task automatic step();
    int          eb;
    bit          ev, ep, erd;
    logic [31:0] ed;
    @(negedge clk);
    eb  = pending.size() - int'(prev_rd);
    ev  = eb != 0;
    ep  = ev & m_ready;
    erd = !rst && !flush && fifo_q.size() != 0 && (pending.size() - int'(ep) < 2);
    ed  = ev ? pending[0] : 32'd0;
    if (started) begin
      chk("rd_en", fifo_rd_en, erd);
      chk("rd_while_empty", fifo_rd_en & fifo_empty, 0);
      chk("m_valid", m_valid, ev);
      chk("m_data", m_data, ed);
      chk("buf_count", buf_count, eb);
      chk("words_out", words_out, exp_words % 16);
    end
    s_rd = fifo_rd_en; s_valid = m_valid; s_data = m_data; s_buf = buf_count; s_words = words_out;
    s_pop = ep; s_rst = rst; s_flush = flush;
    @(posedge clk);
    #1;
    if (s_rst) begin
      pending.delete();
      exp_words = 0;
    end else begin
      if (s_pop) begin void'(pending.pop_front()); exp_words++; end
      if (s_flush) pending.delete();
    end
    if (s_rd === 1'b1 && fifo_q.size() > 0) begin
      fifo_rd_data = fifo_q.pop_front();
      if (!s_rst && !s_flush) pending.push_back(fifo_rd_data);
    end else fifo_rd_data = $urandom;
    prev_rd    = (s_rd === 1'b1) && !s_rst && !s_flush;
    fifo_empty = fifo_q.size() == 0;
    started    = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_q.delete(); fifo_empty = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic        rdy;
    int          cyc;
    logic [1:0]  buf_e;
    logic [3:0]  words_e;
    logic [31:0] data_e;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int          first_rd, first_v, last_v, beats, rds;
    int unsigned nxt, got[$];
    bit          found;
    tbl[0] = '{3, 1'b0, 6, 2'd2, 4'd0, 32'd1};
    tbl[1] = '{3, 1'b1, 8, 2'd0, 4'd3, 32'd0};
    tbl[2] = '{1, 1'b0, 5, 2'd1, 4'd0, 32'd1};
    tbl[3] = '{5, 1'b1, 10, 2'd0, 4'd5, 32'd0};
    tbl[4] = '{0, 1'b1, 4, 2'd0, 4'd0, 32'd0};
    tbl[5] = '{6, 1'b0, 8, 2'd2, 4'd0, 32'd1};

    // reset with a non-empty FIFO
    rst = 1'b1;
    push(32'hA1); push(32'hA2); push(32'hA3);
    step(); step();
    chk("reset_rd_en", s_rd, 0);
    chk("reset_valid", s_valid, 0);
    chk("reset_buf", s_buf, 0);
    chk("reset_words", s_words, 0);

    foreach (tbl[i]) begin
      do_reset();
      m_ready = tbl[i].rdy;
      for (int k = 1; k <= tbl[i].n; k++) push(k);
      repeat (tbl[i].cyc) step();
      chk($sformatf("vec%0d_buf", i), s_buf, tbl[i].buf_e);
      chk($sformatf("vec%0d_words", i), s_words, tbl[i].words_e);
      chk($sformatf("vec%0d_data", i), s_data, tbl[i].data_e);
      chk($sformatf("vec%0d_valid", i), s_valid, tbl[i].buf_e != 0);
    end

    // streaming latency and throughput
    do_reset();
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) push(k);
    first_rd = -1; first_v = -1; last_v = -1; beats = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_rd && first_rd < 0) first_rd = i;
      if (s_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        beats++;
      end
    end
    chk("stream_latency", first_v - first_rd, 2);
    chk("stream_beats", beats, 8);
    chk("stream_consec", last_v - first_v, 7);
    chk("stream_words", s_words, 8);

    // backpressure then release
    do_reset();
    for (int k = 1; k <= 5; k++) push(k);
    repeat (6) step();
    chk("bp_buf", s_buf, 2);
    chk("bp_rd_en", s_rd, 0);
    chk("bp_data", s_data, 1);
    m_ready = 1'b1;
    got.delete();
    repeat (10) begin
      step();
      if (s_valid) got.push_back(s_data);
    end
    chk("bp_count", got.size(), 5);
    foreach (got[i]) chk($sformatf("bp_order%0d", i), got[i], i + 1);

    // single word: one read, one beat
    do_reset();
    m_ready = 1'b1;
    push(32'h77);
    rds = 0; beats = 0;
    repeat (8) begin
      step();
      rds += int'(s_rd);
      beats += int'(s_valid);
    end
    chk("single_rd", rds, 1);
    chk("single_beat", beats, 1);

    // flush while streaming with a read in flight, then flush with full buffer
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) push(32'h50 + k);
    repeat (4) step();
    flush = 1'b1;
    nxt = fifo_q[0];
    step();
    flush = 1'b0;
    step();
    chk("flush_valid", s_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_valid) begin
        found = 1'b1;
        chk("flush_next", s_data, nxt);
      end
    end
    chk("flush_resume", found, 1);
    m_ready = 1'b0;
    repeat (4) step();
    chk("flush2_buf", s_buf, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    m_ready = 1'b1;
    step();
    chk("flush2_valid", s_valid, 0);
    chk("flush2_buf0", s_buf, 0);
    repeat (12) step();

    // counter wrap and mid-stream reset
    do_reset();
    m_ready = 1'b1;
    for (int k = 1; k <= 17; k++) push(k);
    repeat (25) step();
    chk("wrap_words", s_words, 1);
    for (int k = 0; k < 5; k++) push(32'h90 + k);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("midrst_valid", s_valid, 0);
    chk("midrst_buf", s_buf, 0);
    chk("midrst_words", s_words, 0);
    chk("midrst_data", s_data, 0);
    repeat (10) step();

    // random traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() < 8 && $urandom_range(1, 0) == 1) push($urandom);
      m_ready = $urandom_range(3, 0) != 0;
      flush   = $urandom_range(31, 0) == 0;
      rst     = $urandom_range(99, 0) == 0;
      step();
    end
    rst = 1'b0; flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
